// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM states, coin encodings
// and the coin-to-credit conversion.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_VEND,
        ST_CHANGE
    } vend_state_t;

    localparam logic [1:0] COIN_INVALID = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    // Value of a coin in 5-cent units; invalid coins are worth nothing.
    function automatic logic [2:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_NICKEL:  coin_value = 3'd1;
            COIN_DIME:    coin_value = 3'd2;
            COIN_QUARTER: coin_value = 3'd5;
            default:      coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// VEND-phase watchdog: counts cycles while enabled, cleared whenever the
// controller is outside VEND, and flags the last permitted cycle.
module vend_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: accumulates credit, requests a vend at
// the item price, and refunds remaining credit one nickel every other cycle.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_UNITS = 8,
    parameter int CREDIT_W    = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic                vend_req,
    output logic                change_pulse,
    output logic                vend_fault,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);

    vend_state_t         state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [CREDIT_W-1:0] coin_sum;
    logic                phase, phase_n;
    logic                accept_n, reject_n, pulse_n, fault_n;
    logic                timer_expired;

    vend_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != ST_VEND),
        .enable (state == ST_VEND),
        .expired(timer_expired)
    );

    always_comb begin
        state_n  = state;
        credit_n = credit;
        phase_n  = phase;
        accept_n = 1'b0;
        reject_n = 1'b0;
        pulse_n  = 1'b0;
        fault_n  = 1'b0;
        coin_sum = credit + CREDIT_W'(coin_value(coin_type));

        case (state)
            ST_IDLE, ST_ACCUM: begin
                // Cancel outranks a simultaneous coin, which is handed back.
                if (state == ST_ACCUM && cancel) begin
                    state_n  = ST_CHANGE;
                    phase_n  = 1'b0;
                    reject_n = coin_valid;
                end else if (coin_valid) begin
                    if (coin_type == COIN_INVALID) begin
                        reject_n = 1'b1;
                    end else begin
                        credit_n = coin_sum;
                        accept_n = 1'b1;
                        state_n  = (coin_sum >= PRICE) ? ST_VEND : ST_ACCUM;
                    end
                end
            end

            ST_VEND: begin
                reject_n = coin_valid;
                if (vend_ack) begin
                    credit_n = credit - PRICE;
                    state_n  = (credit_n != '0) ? ST_CHANGE : ST_IDLE;
                    phase_n  = 1'b0;
                end else if (timer_expired) begin
                    fault_n = 1'b1;
                    state_n = ST_CHANGE;
                    phase_n = 1'b0;
                end
            end

            ST_CHANGE: begin
                reject_n = coin_valid;
                if (phase) begin
                    phase_n = 1'b0;
                    if (credit == '0) begin
                        state_n = ST_IDLE;
                    end
                end else if (credit == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    credit_n = credit - 1'b1;
                    pulse_n  = 1'b1;
                    phase_n  = 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            credit       <= '0;
            phase        <= 1'b0;
            coin_accept  <= 1'b0;
            coin_reject  <= 1'b0;
            change_pulse <= 1'b0;
            vend_fault   <= 1'b0;
            vend_req     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            phase        <= phase_n;
            coin_accept  <= accept_n;
            coin_reject  <= reject_n;
            change_pulse <= pulse_n;
            vend_fault   <= fault_n;
            vend_req     <= (state_n == ST_VEND);
            busy         <= (state_n == ST_VEND) || (state_n == ST_CHANGE);
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_vend_controller;

    localparam int PRICE = 8;
    localparam int CW    = 5;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_type = 2'b00;
    logic          cancel = 1'b0;
    logic          vend_ack = 1'b0;
    logic          coin_accept, coin_reject, vend_req, change_pulse, vend_fault, busy;
    logic [CW-1:0] credit;

    always #5 clk = ~clk;

    vend_controller #(
        .PRICE_UNITS(PRICE),
        .CREDIT_W   (CW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .cancel      (cancel),
        .vend_ack    (vend_ack),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject),
        .vend_req    (vend_req),
        .change_pulse(change_pulse),
        .vend_fault  (vend_fault),
        .credit      (credit),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: credit balance plus "vending" / "refunding" activities.
    int m_credit;
    bit m_vend;
    int m_age;
    bit m_refund;
    int m_tick;
    bit e_accept, e_reject, e_change, e_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int coin_units(input logic [1:0] t);
        case (t)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_credit = 0;
        m_vend   = 1'b0;
        m_age    = 0;
        m_refund = 1'b0;
        m_tick   = 0;
        e_accept = 1'b0;
        e_reject = 1'b0;
        e_change = 1'b0;
        e_fault  = 1'b0;
    endtask

    task automatic model_step();
        e_accept = 1'b0;
        e_reject = 1'b0;
        e_change = 1'b0;
        e_fault  = 1'b0;
        if (m_vend) begin
            m_age++;
            e_reject = coin_valid;
            if (vend_ack) begin
                m_credit -= PRICE;
                m_vend = 1'b0;
                if (m_credit > 0) begin
                    m_refund = 1'b1;
                    m_tick   = 0;
                end
            end else if (m_age == TMO) begin
                e_fault  = 1'b1;
                m_vend   = 1'b0;
                m_refund = 1'b1;
                m_tick   = 0;
            end
        end else if (m_refund) begin
            e_reject = coin_valid;
            m_tick++;
            if (m_tick % 2 == 1) begin
                m_credit--;
                e_change = 1'b1;
            end else if (m_credit == 0) begin
                m_refund = 1'b0;
            end
        end else begin
            if (cancel && m_credit > 0) begin
                e_reject = coin_valid;
                m_refund = 1'b1;
                m_tick   = 0;
            end else if (coin_valid) begin
                if (coin_type == 2'b00) begin
                    e_reject = 1'b1;
                end else begin
                    m_credit += coin_units(coin_type);
                    e_accept = 1'b1;
                    if (m_credit >= PRICE) begin
                        m_vend = 1'b1;
                        m_age  = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("credit", 32'(credit), 32'(m_credit));
        chk("coin_accept", 32'(coin_accept), 32'(e_accept));
        chk("coin_reject", 32'(coin_reject), 32'(e_reject));
        chk("change_pulse", 32'(change_pulse), 32'(e_change));
        chk("vend_fault", 32'(vend_fault), 32'(e_fault));
        chk("vend_req", 32'(vend_req), 32'(m_vend));
        chk("busy", 32'(busy), 32'(m_vend || m_refund));
    endtask

    // One clock: apply inputs, advance model on the edge, compare on the falling edge.
    task automatic step(input bit cv, input logic [1:0] ct, input bit cn, input bit ak);
        coin_valid = cv;
        coin_type  = ct;
        cancel     = cn;
        vend_ack   = ak;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        cancel     = 1'b0;
        vend_ack   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Run idle cycles until refund completes; returns number of change pulses seen.
    task automatic drain(input string name, output int pulses);
        int k;
        pulses = 0;
        k = 0;
        while ((m_vend || m_refund) && k < 200) begin
            step(1'b0, 2'b00, 1'b0, 1'b0);
            if (change_pulse) pulses++;
            k++;
        end
        chk({name, "_drain_bound"}, 32'(k < 200), 32'd1);
    endtask

    initial begin
        int pulses;
        int accepts;
        int last;
        int vc;
        int k;
        bit seen;
        int exp_cr [4];

        model_reset();
        #12;
        chk("reset_credit", 32'(credit), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_vend_req", 32'(vend_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Invalid coin in IDLE
        step(1'b1, 2'b00, 1'b0, 1'b0);
        chk("t038_reject", 32'(coin_reject), 32'd1);
        chk("t038_credit", 32'(credit), 32'd0);
        chk("t038_busy", 32'(busy), 32'd0);

        // Four dimes, exact price
        exp_cr = '{2, 4, 6, 8};
        accepts = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b10, 1'b0, 1'b0);
            chk("t034_credit", 32'(credit), 32'(exp_cr[i]));
            if (coin_accept) accepts++;
        end
        chk("t034_accepts", 32'(accepts), 32'd4);
        chk("t034_vend_req", 32'(vend_req), 32'd1);
        idle(3);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("t034_credit_after", 32'(credit), 32'd0);
        chk("t034_vend_req_drop", 32'(vend_req), 32'd0);
        chk("t034_busy_after", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'b00, 1'b0, 1'b0);
            if (change_pulse) pulses++;
        end
        chk("t034_no_change", 32'(pulses), 32'd0);

        // Quarter, dime, quarter: vend then four nickels of change
        step(1'b1, 2'b11, 1'b0, 1'b0);
        chk("t035_c5", 32'(credit), 32'd5);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        chk("t035_c7", 32'(credit), 32'd7);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        chk("t035_c12", 32'(credit), 32'd12);
        chk("t035_vend_req", 32'(vend_req), 32'd1);
        idle(2);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("t035_rem", 32'(credit), 32'd4);
        chk("t035_busy", 32'(busy), 32'd1);
        pulses = 0;
        last = 0;
        k = 0;
        while (m_refund && k < 40) begin
            step(1'b0, 2'b00, 1'b0, 1'b0);
            if (change_pulse) begin
                if (pulses > 0) chk("t035_spacing", 32'(k - last), 32'd2);
                last = k;
                pulses++;
            end
            k++;
        end
        chk("t035_pulses", 32'(pulses), 32'd4);
        chk("t035_credit_end", 32'(credit), 32'd0);
        chk("t035_busy_end", 32'(busy), 32'd0);

        // Coin during VEND, then cancel with a coin at credit 3
        step(1'b1, 2'b11, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        chk("t036_vend", 32'(vend_req), 32'd1);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t036_vend_reject", 32'(coin_reject), 32'd1);
        chk("t036_vend_credit", 32'(credit), 32'd8);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        chk("t036_c3", 32'(credit), 32'd3);
        step(1'b1, 2'b10, 1'b1, 1'b0);
        chk("t036_cancel_reject", 32'(coin_reject), 32'd1);
        chk("t036_cancel_accept", 32'(coin_accept), 32'd0);
        chk("t036_cancel_credit", 32'(credit), 32'd3);
        drain("t036", pulses);
        chk("t036_pulses", 32'(pulses), 32'd3);

        // Vend timeout with full refund
        for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 1'b0, 1'b0);
        vc = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1'b0, 2'b00, 1'b0, 1'b0);
            if (vend_fault) seen = 1'b1;
            else if (vend_req) vc++;
        end
        chk("t037_fault_seen", 32'(seen), 32'd1);
        chk("t037_vend_cycles", 32'(vc), 32'(TMO));
        chk("t037_credit_kept", 32'(credit), 32'd8);
        drain("t037", pulses);
        chk("t037_pulses", 32'(pulses), 32'd8);

        // Asynchronous reset in the middle of a refund at credit 3
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        k = 0;
        while (m_credit != 3 && k < 20) begin
            step(1'b0, 2'b00, 1'b0, 1'b0);
            k++;
        end
        chk("t033_reached3", 32'(credit), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t033_async_credit", 32'(credit), 32'd0);
        chk("t033_async_busy", 32'(busy), 32'd0);
        chk("t033_async_pulse", 32'(change_pulse), 32'd0);
        @(negedge clk);
        chk("t033_hold_pulse", 32'(change_pulse), 32'd0);
        chk("t033_hold_credit", 32'(credit), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit cv;
            bit cn;
            bit ak;
            cv = ($urandom % 100) < 30;
            cn = ($urandom % 100) < 4;
            ak = m_vend ? (($urandom % 100) < 10) : (($urandom % 100) < 3);
            step(cv, 2'($urandom % 4), cn, ak);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE_UNITS, default 8, meaning item price in 5-cent units (40c).
REQ-002 SHALL have parameter CREDIT_W, default 5, meaning credit register width; must satisfy 2**CREDIT_W > PRICE_UNITS+4.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning maximum VEND cycles awaiting vend_ack.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 coin_valid  input  1  single-cycle coin strobe.
REQ-007 coin_type  input  2  00 invalid, 01 nickel (1 unit), 10 dime (2 units), 11 quarter (5 units).
REQ-008 cancel  input  1  refund request, level sampled each cycle.
REQ-009 vend_ack  input  1  dispenser accepted vend.
REQ-010 coin_accept  output  1  one-cycle pulse, coin credited.
REQ-011 coin_reject  output  1  one-cycle pulse, coin returned.
REQ-012 vend_req  output  1  level, held through VEND.
REQ-013 change_pulse  output  1  one-cycle pulse per nickel returned.
REQ-014 vend_fault  output  1  one-cycle pulse on vend timeout.
REQ-015 credit  output  CREDIT_W  current credit, units.
REQ-016 busy  output  1  high in VEND or CHANGE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, VEND, CHANGE; all outputs registered.
REQ-018 IDLE/ACCUM, coin_valid with coin_type!=00: credit += value next cycle, coin_accept pulses same cycle as updated credit.
REQ-019 coin_valid with coin_type==00 in any state SHALL pulse coin_reject next cycle, credit unchanged.
REQ-020 After a credit update, credit>=PRICE_UNITS -> VEND; credit>0 -> ACCUM; transition coincident with credit update.
REQ-021 ACCUM with cancel -> CHANGE, credit retained; cancel and valid coin same cycle: cancel wins, coin rejected.
REQ-022 VEND: vend_req=1; coins rejected; cancel ignored; timer counts from 0 on entry.
REQ-023 VEND with vend_ack: credit -= PRICE_UNITS; remainder>0 -> CHANGE, else IDLE; vend_req drops same cycle.
REQ-024 VEND timer reaching TIMEOUT_CYC-1 without vend_ack: vend_fault pulse, credit retained, -> CHANGE (full refund); vend_ack same cycle wins.
REQ-025 CHANGE: alternating pulse/gap cycles; each change_pulse cycle decrements credit by 1; credit reaching 0 -> IDLE after gap cycle; coins rejected, cancel ignored.
REQ-026 busy SHALL equal (state==VEND || state==CHANGE) from registered state.
REQ-027 credit arithmetic SHALL be CREDIT_W unsigned, no wrap reachable given REQ-002.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, credit=0, all pulses and vend_req low, timer=0, independent of clk.
REQ-029 Reset mid-VEND or mid-CHANGE SHALL discard credit with no further change_pulse.
REQ-030 First state change SHALL occur on first rising clk edge after rst_n deasserts.

Structure
REQ-031 Package vend_pkg SHALL hold state enum, coin_type encoding constants, and coin-value function.
REQ-032 Single sub-module vend_timer (load/clear, count, expire flag) SHALL implement the VEND timeout.

Verification
REQ-033 Reset asserted mid-CHANGE at credit 3 -> credit 0, IDLE, no change_pulse, async (before next edge).
REQ-034 Four dimes -> credit 2,4,6,8, four coin_accept; VEND, vend_req=1; vend_ack -> IDLE, credit 0, zero change_pulse.
REQ-035 Quarter, dime, quarter -> credit 5,7,12; VEND; vend_ack -> CHANGE, four change_pulse two cycles apart, credit 4->0, IDLE.
REQ-036 Nickel during VEND -> coin_reject, credit unchanged; cancel plus dime at credit 3 -> coin_reject, three change_pulse.
REQ-037 TIMEOUT_CYC=16, credit 8, no vend_ack -> vend_fault on 16th VEND cycle, eight change_pulse, IDLE.
REQ-038 coin_type 00 strobe in IDLE -> coin_reject, state IDLE, credit 0.
